// File: rtl/card_display_scanner_if.sv
// card_display_scanner_if: card write (valid/ready) and commit port of the display scanner.
// The index is one bit wider than strictly needed, so out-of-range slots can be addressed (and are dropped).
interface card_display_scanner_if #(
    parameter int NUM_CARDS = 4
);
    localparam int IW = $clog2(NUM_CARDS + 1);
    logic          card_valid_in;
    logic          card_ready_out;
    logic [IW-1:0] card_idx_in;
    logic [3:0]    card_rank_in;
    logic [1:0]    card_suit_in;
    logic          commit_in;
    logic          commit_pending_out;
    modport master (
        output card_valid_in, card_idx_in, card_rank_in, card_suit_in, commit_in,
        input  card_ready_out, commit_pending_out
    );
    modport slave (
        input  card_valid_in, card_idx_in, card_rank_in, card_suit_in, commit_in,
        output card_ready_out, commit_pending_out
    );
endinterface

// File: rtl/card_display_scanner.sv
// card_display_scanner: double-buffered 7-segment scan controller, two digits (suit, rank) per card.
// Optional CARD_HIGHLIGHT_EN adds a per-card blink mask driven by a 6-bit frame counter.
module card_display_scanner #(
    parameter int COUNT_PERIOD = 100000,
    parameter int NUM_CARDS    = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    card_display_scanner_if.slave  bus,
`ifdef CARD_HIGHLIGHT_EN
    input  logic [NUM_CARDS-1:0]   highlight_mask_in,
`endif
    output logic                   frame_tick_out,
    output logic [2*NUM_CARDS-1:0] an_out,
    output logic [6:0]             cat_out
);
    localparam int ND = 2 * NUM_CARDS;
    localparam int CW = $clog2(COUNT_PERIOD);
    localparam int DW = (ND > 1) ? $clog2(ND) : 1;
    localparam int KW = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
    localparam int IW = $clog2(NUM_CARDS + 1);
    // Active-high segment masks indexed by rank (0, 14, 15 blank) and by suit.
    localparam logic [15:0][6:0] RANK_G = {7'h00, 7'h00, 7'h76, 7'h67, 7'h1E, 7'h3F, 7'h6F, 7'h7F,
                                           7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h77, 7'h00};
    localparam logic [3:0][6:0]  SUIT_G = {7'h6D, 7'h58, 7'h74, 7'h5E};

    logic [CW-1:0]                cnt_q, cnt_d;
    logic [DW-1:0]                dig_q, dig_d;
    logic [NUM_CARDS-1:0][5:0]    act_q, act_d, shd_q, shd_d;
    logic                         pend_q, pend_d;
    logic [ND-1:0]                an_q, an_d;
    logic [6:0]                   cat_q, cat_d;
    logic                         wrap, frame, wr_en, blank;
    logic [KW-1:0]                ci;
    logic [5:0]                   card;
`ifdef CARD_HIGHLIGHT_EN
    logic [5:0]                   fcnt_q, fcnt_d;
`endif

    assign bus.card_ready_out     = rst_n_in && !pend_q;
    assign bus.commit_pending_out = pend_q;
    assign frame_tick_out         = frame;
    assign an_out                 = an_q;
    assign cat_out                = cat_q;

    always_comb begin
        wrap   = cnt_q == CW'(COUNT_PERIOD - 1);
        frame  = wrap && dig_q == DW'(ND - 1);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        dig_d  = !wrap ? dig_q : frame ? '0 : dig_q + 1'b1;
        wr_en  = bus.card_valid_in && bus.card_ready_out && bus.card_idx_in < IW'(NUM_CARDS);
        shd_d  = shd_q;
        if (wr_en)
            shd_d[bus.card_idx_in[KW-1:0]] = {bus.card_rank_in, bus.card_suit_in};
        // The swap only happens on the frame boundary so a frame never mixes old and new cards.
        act_d  = (frame && pend_q) ? shd_q : act_q;
        pend_d = pend_q ? !frame : bus.commit_in;
        ci     = KW'(dig_q >> 1);
        card   = act_q[ci];
`ifdef CARD_HIGHLIGHT_EN
        fcnt_d = fcnt_q + {5'b0, frame};
        blank  = RANK_G[card[5:2]] == '0 || (highlight_mask_in[ci] && fcnt_q[5]);
`else
        blank  = RANK_G[card[5:2]] == '0;
`endif
        an_d   = ~(ND'(1) << dig_q);
        cat_d  = blank ? 7'h7F : ~(dig_q[0] ? RANK_G[card[5:2]] : SUIT_G[card[1:0]]);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q  <= '0;
            dig_q  <= '0;
            act_q  <= '0;
            shd_q  <= '0;
            pend_q <= 1'b0;
            an_q   <= '1;
            cat_q  <= '1;
`ifdef CARD_HIGHLIGHT_EN
            fcnt_q <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            an_q   <= an_d;
            cat_q  <= cat_d;
`ifdef CARD_HIGHLIGHT_EN
            fcnt_q <= fcnt_d;
`endif
        end
    end
endmodule
